fetcher: RTL and testbench

Per-core instruction fetcher: the responder half of the core-state/fetcher-state protocol driven by the warp scheduler. When the scheduler enters FETCH it reads the selected warp's PC from program memory through a valid/ready channel, reports FETCHED, and holds the instruction for the decoder until the scheduler moves to DECODE. An optional per-warp single-entry instruction buffer removes the memory round trip when a warp re-fetches the same PC.

---
 rtl/fetcher_if.sv | 24 ++
 rtl/fetcher.sv | 121 ++++++++++++
 tb/tb_fetcher.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/fetcher_if.sv
// Program-memory read channel between the fetcher (master) and instruction memory (slave).
interface fetcher_if #(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 16
);
    logic                 mem_read_valid;
    logic [ADDR_BITS-1:0] mem_read_address;
    logic                 mem_read_ready;
    logic [DATA_BITS-1:0] mem_read_data;

    modport master (
        output mem_read_valid,
        output mem_read_address,
        input  mem_read_ready,
        input  mem_read_data
    );

    modport slave (
        input  mem_read_valid,
        input  mem_read_address,
        output mem_read_ready,
        output mem_read_data
    );
endinterface

// File: rtl/fetcher.sv
// Per-core instruction fetcher answering the scheduler's FETCH/DECODE handshake.
// Optional per-warp single-entry instruction buffer enabled by defining FETCHER_IBUF_EN.
module fetcher #(
    parameter int MAX_WARPS_PER_CORE    = 2,
    parameter int WARP_ID_BITS          = (MAX_WARPS_PER_CORE > 1) ? $clog2(MAX_WARPS_PER_CORE) : 1,
    parameter int PROGRAM_MEM_ADDR_BITS = 8,
    parameter int PROGRAM_MEM_DATA_BITS = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [2:0]                       core_state,
    input  logic [WARP_ID_BITS-1:0]          current_warp_id,
    input  logic [PROGRAM_MEM_ADDR_BITS-1:0] warp_pc,
    input  logic                             ibuf_flush,
    fetcher_if.master                        mem,
    output logic [2:0]                       fetcher_state,
    output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction
);
    localparam logic [2:0] CORE_FETCH  = 3'b001;
    localparam logic [2:0] CORE_DECODE = 3'b010;

    typedef enum logic [2:0] {
        S_IDLE     = 3'b000,
        S_FETCHING = 3'b001,
        S_FETCHED  = 3'b010
    } state_t;

    state_t                           r_state;
    logic                             r_valid;
    logic [PROGRAM_MEM_ADDR_BITS-1:0] r_addr;
    logic [PROGRAM_MEM_DATA_BITS-1:0] r_instr;
    logic [WARP_ID_BITS-1:0]          r_fetch_warp;

    logic                             w_hit;
    logic [PROGRAM_MEM_DATA_BITS-1:0] w_hit_data;

`ifdef FETCHER_IBUF_EN
    logic [MAX_WARPS_PER_CORE-1:0]    r_ibuf_vld;
    logic [PROGRAM_MEM_ADDR_BITS-1:0] r_ibuf_tag  [MAX_WARPS_PER_CORE];
    logic [PROGRAM_MEM_DATA_BITS-1:0] r_ibuf_data [MAX_WARPS_PER_CORE];
    logic                             w_fill;

    assign w_fill     = (r_state == S_FETCHING) && mem.mem_read_ready;
    assign w_hit      = r_ibuf_vld[current_warp_id] && (r_ibuf_tag[current_warp_id] == warp_pc);
    assign w_hit_data = r_ibuf_data[current_warp_id];

    // Flush wins over a same-edge fill; the in-flight request itself is untouched.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ibuf_vld <= '0;
        end else if (ibuf_flush) begin
            r_ibuf_vld <= '0;
        end else if (w_fill) begin
            r_ibuf_vld[r_fetch_warp] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_fill) begin
            r_ibuf_tag[r_fetch_warp]  <= r_addr;
            r_ibuf_data[r_fetch_warp] <= mem.mem_read_data;
        end
    end
`else
    logic w_unused_flush;

    assign w_hit          = 1'b0;
    assign w_hit_data     = '0;
    assign w_unused_flush = ibuf_flush;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_valid      <= 1'b0;
            r_addr       <= '0;
            r_instr      <= '0;
            r_fetch_warp <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (core_state == CORE_FETCH) begin
                        r_fetch_warp <= current_warp_id;
                        if (w_hit) begin
                            r_instr <= w_hit_data;
                            r_state <= S_FETCHED;
                        end else begin
                            r_valid <= 1'b1;
                            r_addr  <= warp_pc;
                            r_state <= S_FETCHING;
                        end
                    end
                end
                // Once issued, the request stays up until memory answers.
                S_FETCHING: begin
                    if (mem.mem_read_ready) begin
                        r_instr <= mem.mem_read_data;
                        r_valid <= 1'b0;
                        r_state <= S_FETCHED;
                    end
                end
                S_FETCHED: begin
                    if (core_state == CORE_DECODE) begin
                        r_state <= S_IDLE;
                    end else if ((core_state == CORE_FETCH) && (current_warp_id != r_fetch_warp)) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign mem.mem_read_valid   = r_valid;
    assign mem.mem_read_address = r_addr;
    assign fetcher_state        = r_state;
    assign instruction          = r_instr;
endmodule

// File: tb/tb_fetcher.sv
// Self-checking bench for fetcher: vector table of memory fetches plus hand-written corner sequences.
module tb_fetcher;
    localparam logic [2:0] ST_IDLE     = 3'b000;
    localparam logic [2:0] ST_FETCHING = 3'b001;
    localparam logic [2:0] ST_FETCHED  = 3'b010;
    localparam logic [2:0] CS_NONE     = 3'b000;
    localparam logic [2:0] CS_FETCH    = 3'b001;
    localparam logic [2:0] CS_DECODE   = 3'b010;

    logic        clk;
    logic        reset;
    logic [2:0]  core_state;
    logic [0:0]  current_warp_id;
    logic [7:0]  warp_pc;
    logic        ibuf_flush;
    logic [2:0]  fetcher_state;
    logic [15:0] instruction;

    fetcher_if #(.ADDR_BITS(8), .DATA_BITS(16)) mem_if ();

    fetcher #(
        .MAX_WARPS_PER_CORE(2),
        .PROGRAM_MEM_ADDR_BITS(8),
        .PROGRAM_MEM_DATA_BITS(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .core_state(core_state),
        .current_warp_id(current_warp_id),
        .warp_pc(warp_pc),
        .ibuf_flush(ibuf_flush),
        .mem(mem_if),
        .fetcher_state(fetcher_state),
        .instruction(instruction)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [0:0]  warp;
        logic [7:0]  pc;
        logic [15:0] data;
        int          dly;
    } vec_t;

    int          errors = 0;
    int          checks = 0;
    logic [15:0] exp_q[$];
    logic [15:0] last_instr;
    vec_t        vecs[5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Miss fetch: request held for dly cycles, then answered; optionally retire via DECODE.
    task automatic do_fetch(input logic [0:0] w, input logic [7:0] pc, input logic [15:0] d,
                            input int dly, input bit dec);
        bit          done;
        logic [15:0] e;
        @(negedge clk);
        core_state      = CS_FETCH;
        current_warp_id = w;
        warp_pc         = pc;
        exp_q.push_back(d);
        @(negedge clk);
        core_state = CS_NONE;
        chk("req_state", fetcher_state, ST_FETCHING);
        done = 1'b0;
        for (int k = 1; k <= 20 && !done; k++) begin
            chk("req_valid", mem_if.mem_read_valid, 1);
            chk("req_addr", mem_if.mem_read_address, pc);
            if (k == dly) begin
                mem_if.mem_read_ready = 1'b1;
                mem_if.mem_read_data  = d;
                done = 1'b1;
            end
            @(negedge clk);
            mem_if.mem_read_ready = 1'b0;
            mem_if.mem_read_data  = 16'h0000;
        end
        if (!done) chk("req_timeout", 0, 1);
        chk("done_state", fetcher_state, ST_FETCHED);
        chk("done_valid", mem_if.mem_read_valid, 0);
        if (exp_q.size() == 0) begin
            chk("sb_empty", 0, 1);
        end else begin
            e = exp_q.pop_front();
            chk("done_instr", instruction, e);
            last_instr = e;
        end
        if (dec) begin
            core_state = CS_FETCH;
            @(negedge clk);
            chk("hold_fetched", fetcher_state, ST_FETCHED);
            core_state = CS_DECODE;
            @(negedge clk);
            core_state = CS_NONE;
            chk("decode_idle", fetcher_state, ST_IDLE);
            chk("decode_instr", instruction, last_instr);
        end
    endtask

`ifdef FETCHER_IBUF_EN
    task automatic do_hit(input logic [0:0] w, input logic [7:0] pc, input logic [15:0] d);
        @(negedge clk);
        core_state      = CS_FETCH;
        current_warp_id = w;
        warp_pc         = pc;
        @(posedge clk);
        #1 chk("hit_novalid", mem_if.mem_read_valid, 0);
        @(negedge clk);
        core_state = CS_DECODE;
        chk("hit_state", fetcher_state, ST_FETCHED);
        chk("hit_instr", instruction, d);
        chk("hit_novalid2", mem_if.mem_read_valid, 0);
        @(negedge clk);
        core_state = CS_NONE;
        chk("hit_idle", fetcher_state, ST_IDLE);
    endtask
`endif

    initial begin
        vecs[0] = '{warp: 1'b0, pc: 8'h05, data: 16'hA1B2, dly: 3};
        vecs[1] = '{warp: 1'b1, pc: 8'h20, data: 16'h1234, dly: 1};
        vecs[2] = '{warp: 1'b0, pc: 8'hFF, data: 16'hFFFF, dly: 2};
        vecs[3] = '{warp: 1'b1, pc: 8'h00, data: 16'h0000, dly: 4};
        vecs[4] = '{warp: 1'b0, pc: 8'h80, data: 16'h8001, dly: 1};

        reset                 = 1'b0;
        core_state            = CS_NONE;
        current_warp_id       = 1'b0;
        warp_pc               = 8'h00;
        ibuf_flush            = 1'b0;
        mem_if.mem_read_ready = 1'b0;
        mem_if.mem_read_data  = 16'h0000;
        last_instr            = 16'h0000;
        repeat (2) @(negedge clk);
        chk("rst_state", fetcher_state, ST_IDLE);
        chk("rst_valid", mem_if.mem_read_valid, 0);
        chk("rst_addr", mem_if.mem_read_address, 0);
        chk("rst_instr", instruction, 0);
        reset = 1'b1;

        foreach (vecs[i]) do_fetch(vecs[i].warp, vecs[i].pc, vecs[i].data, vecs[i].dly, 1'b1);

        // Ready without a request must be ignored.
        @(negedge clk);
        mem_if.mem_read_ready = 1'b1;
        mem_if.mem_read_data  = 16'hDEAD;
        repeat (3) @(negedge clk);
        chk("stray_state", fetcher_state, ST_IDLE);
        chk("stray_valid", mem_if.mem_read_valid, 0);
        chk("stray_instr", instruction, last_instr);
        mem_if.mem_read_ready = 1'b0;
        mem_if.mem_read_data  = 16'h0000;

        // Warp skip: scheduler moves to warp 1 while warp 0's instruction is held.
        do_fetch(1'b0, 8'h30, 16'h3030, 2, 1'b0);
        core_state      = CS_FETCH;
        current_warp_id = 1'b1;
        warp_pc         = 8'h20;
        @(negedge clk);
        chk("skip_idle", fetcher_state, ST_IDLE);
        chk("skip_novalid", mem_if.mem_read_valid, 0);
        @(negedge clk);
        core_state = CS_NONE;
        chk("skip_req_state", fetcher_state, ST_FETCHING);
        chk("skip_req_addr", mem_if.mem_read_address, 8'h20);
        mem_if.mem_read_ready = 1'b1;
        mem_if.mem_read_data  = 16'h2020;
        @(negedge clk);
        mem_if.mem_read_ready = 1'b0;
        chk("skip_done", fetcher_state, ST_FETCHED);
        chk("skip_instr", instruction, 16'h2020);
        core_state = CS_DECODE;
        @(negedge clk);
        core_state = CS_NONE;
        chk("skip_dec_idle", fetcher_state, ST_IDLE);

        // Asynchronous reset in the middle of an outstanding request.
        core_state      = CS_FETCH;
        current_warp_id = 1'b0;
        warp_pc         = 8'h12;
        @(negedge clk);
        core_state = CS_NONE;
        chk("mid_valid", mem_if.mem_read_valid, 1);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_state", fetcher_state, ST_IDLE);
        chk("mid_rst_valid", mem_if.mem_read_valid, 0);
        chk("mid_rst_addr", mem_if.mem_read_address, 0);
        chk("mid_rst_instr", instruction, 0);
        @(negedge clk);
        reset = 1'b1;
        do_fetch(1'b0, 8'h12, 16'h5A5A, 2, 1'b1);

`ifdef FETCHER_IBUF_EN
        do_fetch(1'b0, 8'h07, 16'h1111, 1, 1'b1);
        do_hit(1'b0, 8'h07, 16'h1111);
        @(negedge clk);
        ibuf_flush = 1'b1;
        @(negedge clk);
        ibuf_flush = 1'b0;
        do_fetch(1'b0, 8'h07, 16'h1111, 2, 1'b1);
        do_fetch(1'b1, 8'h07, 16'h7777, 1, 1'b1);
        do_hit(1'b1, 8'h07, 16'h7777);
`endif

        chk("sb_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
